// File: rtl/chip8_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | chip8_pkg : shared constants for the CHIP-8 timer/refresh blocks  |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
package chip8_pkg;

    localparam int CHIP8_TICK_DIV_60HZ = 833333;
    localparam int DT_CH               = 0;
    localparam int ST_CH               = 1;
    localparam int CHIP8_TIMER_WIDTH   = 8;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/chip8_timer_bank_if.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | chip8_timer_bank_if : CPU-side write/read port of the timer bank  |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
interface chip8_timer_bank_if
    import chip8_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int WIDTH  = CHIP8_TIMER_WIDTH
);
    localparam int CH_W = clog2_min1(NUM_CH);

    logic             wr_en;
    logic [CH_W-1:0]  wr_ch;
    logic [WIDTH-1:0] wr_data;
    logic [CH_W-1:0]  rd_ch;
    logic [WIDTH-1:0] rd_data;

    modport master (output wr_en, wr_ch, wr_data, rd_ch, input rd_data);
    modport slave  (input wr_en, wr_ch, wr_data, rd_ch, output rd_data);

endinterface
`default_nettype wire

// File: rtl/chip8_prescaler.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | chip8_prescaler : divides clk into a one-cycle tick every         |
// | TICK_DIV enabled cycles, with a synchronous phase restart.        |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module chip8_prescaler
    import chip8_pkg::*;
#(
    parameter int TICK_DIV = CHIP8_TICK_DIV_60HZ
) (
    input  wire  clk,
    input  wire  reset,
    input  wire  run,
    input  wire  tick_sync,
    output logic tick
);
    localparam int              CNT_W = clog2_min1(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            tick  <= 1'b0;
        end else if (tick_sync) begin
            r_cnt <= '0;
            tick  <= 1'b0;
        end else if (run) begin
            if (r_cnt == LAST) begin
                r_cnt <= '0;
                tick  <= 1'b1;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
                tick  <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/chip8_timer_bank.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | chip8_timer_bank : NUM_CH saturating down-counters decremented on |
// | prescaler ticks, with expiry pulses and a sound-timer beep.       |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module chip8_timer_bank
    import chip8_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int WIDTH    = CHIP8_TIMER_WIDTH,
    parameter int TICK_DIV = CHIP8_TICK_DIV_60HZ,
    parameter int SOUND_CH = ST_CH
) (
    input  wire                clk,
    input  wire                reset,
    input  wire                run,
    input  wire                tick_sync,
    chip8_timer_bank_if.slave  bus,
    output logic [NUM_CH-1:0]  active,
    output logic [NUM_CH-1:0]  expired,
    output logic               tick,
    output logic               beep
);
    localparam int CH_W = clog2_min1(NUM_CH);

    logic [WIDTH-1:0] w_count [NUM_CH];

    chip8_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .tick_sync (tick_sync),
        .tick      (tick)
    );

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [WIDTH-1:0] r_cnt;
        logic             r_exp;
        logic             w_wr_hit;

        // Out-of-range wr_ch never matches any channel, so such writes vanish.
        assign w_wr_hit = bus.wr_en && (bus.wr_ch == CH_W'(i));

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_cnt <= '0;
                r_exp <= 1'b0;
            end else if (w_wr_hit) begin
                r_cnt <= bus.wr_data;
                r_exp <= 1'b0;
            end else if (tick && (r_cnt != '0)) begin
                r_cnt <= r_cnt - WIDTH'(1);
                r_exp <= (r_cnt == WIDTH'(1));
            end else begin
                r_exp <= 1'b0;
            end
        end

        assign w_count[i] = r_cnt;
        assign active[i]  = (r_cnt != '0);
        assign expired[i] = r_exp;
    end

    always_comb begin
        bus.rd_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.rd_ch == CH_W'(i)) begin
                bus.rd_data = w_count[i];
            end
        end
    end

    if (SOUND_CH < NUM_CH) begin : g_beep
        assign beep = active[SOUND_CH];
    end else begin : g_no_beep
        assign beep = 1'b0;
    end

endmodule
`default_nettype wire

// File: tb/tb_chip8_timer_bank.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_chip8_timer_bank : scoreboard bench with a behavioural model   |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module tb_chip8_timer_bank;
    import chip8_pkg::*;

    localparam int DIV = 4;
    localparam int NCH = 2;
    localparam int W   = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           run = 1'b0;
    logic           tick_sync = 1'b0;
    logic [NCH-1:0] active, expired;
    logic           tick, beep;

    logic           run3 = 1'b0;
    logic           tick_sync3 = 1'b0;
    logic [2:0]     active3, expired3;
    logic           tick3, beep3;

    chip8_timer_bank_if #(.NUM_CH(NCH), .WIDTH(W)) bus ();
    chip8_timer_bank_if #(.NUM_CH(3),   .WIDTH(W)) bus3 ();

    chip8_timer_bank #(
        .NUM_CH(NCH), .WIDTH(W), .TICK_DIV(DIV), .SOUND_CH(1)
    ) dut (
        .clk(clk), .reset(reset), .run(run), .tick_sync(tick_sync),
        .bus(bus), .active(active), .expired(expired), .tick(tick), .beep(beep)
    );

    // Three-channel instance: only here can an index fall outside the bank.
    chip8_timer_bank #(
        .NUM_CH(3), .WIDTH(W), .TICK_DIV(DIV), .SOUND_CH(1)
    ) dut3 (
        .clk(clk), .reset(reset), .run(run3), .tick_sync(tick_sync3),
        .bus(bus3), .active(active3), .expired(expired3), .tick(tick3), .beep(beep3)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   rd;
        logic [NCH-1:0] act;
        logic [NCH-1:0] exp;
        logic           tk;
        logic           bp;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, want, $time);
        end
    endtask

    // Reference model: counts are plain integers, the tick is derived from
    // the number of run-enabled cycles since the last phase anchor.
    int m_cnt [NCH];
    int m_since = 0;
    bit m_tick  = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
            m_since = 0;
            m_tick  = 1'b0;
        end else begin
            exp_t           e;
            logic [NCH-1:0] ex;
            ex = '0;
            for (int i = 0; i < NCH; i++) begin
                if (bus.wr_en && int'(bus.wr_ch) == i) begin
                    m_cnt[i] = int'(bus.wr_data);
                end else if (m_tick && m_cnt[i] > 0) begin
                    if (m_cnt[i] == 1) ex[i] = 1'b1;
                    m_cnt[i] = m_cnt[i] - 1;
                end
            end
            if (tick_sync) begin
                m_since = 0;
                m_tick  = 1'b0;
            end else if (run) begin
                m_since = m_since + 1;
                m_tick  = (m_since % DIV) == 0;
            end else begin
                m_tick = 1'b0;
            end
            e.rd  = (int'(bus.rd_ch) < NCH) ? W'(m_cnt[int'(bus.rd_ch)]) : '0;
            e.act = {m_cnt[1] != 0, m_cnt[0] != 0};
            e.exp = ex;
            e.tk  = m_tick;
            e.bp  = m_cnt[1] != 0;
            sb.push_back(e);
        end
    end

    exp_t got_e;
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            got_e = sb.pop_front();
            chk("rd_data", 32'(bus.rd_data), 32'(got_e.rd));
            chk("active",  32'(active),      32'(got_e.act));
            chk("expired", 32'(expired),     32'(got_e.exp));
            chk("tick",    32'(tick),        32'(got_e.tk));
            chk("beep",    32'(beep),        32'(got_e.bp));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
        bus.wr_en = 1'b0;
        tick_sync = 1'b0;
    endtask

    task automatic wr(input int ch, input int d);
        bus.wr_en   = 1'b1;
        bus.wr_ch   = 1'(ch);
        bus.wr_data = W'(d);
        cyc();
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_rd_data"}, 32'(bus.rd_data), 0);
        chk({tag, "_active"},  32'(active),      0);
        chk({tag, "_expired"}, 32'(expired),     0);
        chk({tag, "_tick"},    32'(tick),        0);
        chk({tag, "_beep"},    32'(beep),        0);
    endtask

    initial begin
        bus.wr_en = 1'b0;  bus.wr_ch = '0;  bus.wr_data = '0;  bus.rd_ch = '0;
        bus3.wr_en = 1'b0; bus3.wr_ch = '0; bus3.wr_data = '0; bus3.rd_ch = '0;

        #1 reset = 1'b1;
        #1 reset_check("reset");
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        run = 1'b1;

        // Countdown of the delay timer through expiry
        bus.rd_ch = 1'b0;
        wr(0, 3);
        repeat (20) cyc();

        // Sound timer drives beep, then saturates at zero
        bus.rd_ch = 1'b1;
        wr(1, 2);
        repeat (60) cyc();

        // Write coinciding with a tick while the count is 1
        bus.rd_ch = 1'b0;
        wr(0, 1);
        begin
            int k = 0;
            while (!tick && k < 2 * DIV) begin
                cyc();
                k++;
            end
            chk("tick_before_collide", 32'(tick), 1);
        end
        wr(0, 5);
        repeat (10) cyc();

        // Overwrite with zero
        wr(0, 7);
        repeat (2) cyc();
        wr(0, 0);
        repeat (10) cyc();

        // Freeze, resume, and phase restart
        wr(0, 4);
        run = 1'b0;
        repeat (20) cyc();
        run = 1'b1;
        repeat (12) cyc();
        tick_sync = 1'b1;
        cyc();
        repeat (12) cyc();

        // Asynchronous reset in the middle of counting
        wr(0, 9);
        wr(1, 3);
        repeat (3) cyc();
        reset = 1'b1;
        #1 reset_check("midreset");
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        repeat (12) cyc();

        // Out-of-range indices on the three-channel bank
        bus3.wr_en = 1'b1; bus3.wr_ch = 2'd3; bus3.wr_data = 8'h55;
        @(posedge clk); #2 bus3.wr_en = 1'b0;
        for (int c = 0; c < 4; c++) begin
            bus3.rd_ch = 2'(c);
            #1 chk("oor_write_rd", 32'(bus3.rd_data), 0);
        end
        chk("oor_write_active", 32'(active3), 0);
        bus3.wr_en = 1'b1; bus3.wr_ch = 2'd2; bus3.wr_data = 8'h21;
        @(posedge clk); #2 bus3.wr_en = 1'b0;
        bus3.rd_ch = 2'd2;
        #1 chk("ch2_rd", 32'(bus3.rd_data), 32'h21);
        bus3.rd_ch = 2'd3;
        #1 chk("oor_rd", 32'(bus3.rd_data), 0);
        chk("ch2_active", 32'(active3), 32'b100);

        // Randomized traffic
        repeat (1500) begin
            run       = ($urandom_range(0, 9) != 0);
            tick_sync = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 3) == 0) begin
                bus.wr_en   = 1'b1;
                bus.wr_ch   = 1'($urandom_range(0, 1));
                bus.wr_data = W'($urandom_range(0, 6));
            end
            bus.rd_ch = 1'($urandom_range(0, 1));
            cyc();
        end

        repeat (2) cyc();
        chk("scoreboard_drained", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
